// File: rtl/inst_fetch_sequencer_if.sv
// Fetch-side handshake and byte-wide instruction memory port of the fetch sequencer.
// The slave modport is the sequencer's view. The master modport is the environment: the IF stage plus the memory.
interface inst_fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        flush;
  logic        valid;
  logic [31:0] inst;
  logic        ack;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req, addr, flush, ack, mem_rdata,
    output ready, valid, inst, mem_rd, mem_addr
  );

  modport master (
    output req, addr, flush, ack, mem_rdata,
    input  ready, valid, inst, mem_rd, mem_addr
  );
endinterface

// File: rtl/inst_fetch_sequencer.sv
// Issues four pipelined byte reads for a 32-bit fetch and assembles the word big-endian.
// Fetches whose last byte falls past the end of memory return NOP_WORD without issuing any read.
module inst_fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 188,
  parameter int unsigned MEM_LAT   = 1,
  parameter logic [31:0] NOP_WORD  = 32'hE000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_fetch_sequencer_if.slave  bus,
  output logic [1:0]             state_o
);
  // Handshakes: req is accepted on an edge where req && ready. inst is
  // consumed on an edge where valid && ack. flush overrides both.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_e;

  localparam logic [31:0] LAST_BASE = 32'(MEM_BYTES - 4);

  state_e              state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic [1:0]          issue_cnt_q, issue_cnt_d;
  logic [1:0]          rx_cnt_q, rx_cnt_d;
  logic [MEM_LAT-1:0]  track_q, track_d;
  logic [31:0]         inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                mem_rd_q, mem_rd_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                accept;
  logic                byte_ret;

  assign bus.ready    = (state_q == IDLE) && !bus.flush;
  assign accept       = bus.req && bus.ready;
  assign byte_ret     = track_q[MEM_LAT-1];
  assign bus.valid    = valid_q;
  assign bus.inst     = inst_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign state_o      = state_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    // The tracker mirrors the memory pipeline, so a byte is taken exactly when its strobe emerges.
    track_d[0]  = mem_rd_q;
    for (int i = 1; i < int'(MEM_LAT); i++) track_d[i] = track_q[i-1];

    if (bus.flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      track_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            base_d      = bus.addr;
            issue_cnt_d = 2'd0;
            rx_cnt_d    = 2'd0;
            if (bus.addr > LAST_BASE) begin
              inst_d  = NOP_WORD;
              valid_d = 1'b1;
              state_d = HOLD;
            end else begin
              mem_rd_d    = 1'b1;
              mem_addr_d  = bus.addr;
              issue_cnt_d = 2'd1;
              state_d     = ISSUE;
            end
          end
        end
        ISSUE: begin
          // issue_cnt wraps to 0 once base+3 has been presented.
          if (issue_cnt_q != 2'd0) begin
            mem_rd_d    = 1'b1;
            mem_addr_d  = base_q + 32'(issue_cnt_q);
            issue_cnt_d = issue_cnt_q + 2'd1;
          end else begin
            state_d = WAIT;
          end
        end
        WAIT: ;
        HOLD: begin
          if (bus.ack) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      endcase

      if (byte_ret && (state_q == ISSUE || state_q == WAIT)) begin
        case (rx_cnt_q)
          2'd0: inst_d[31:24] = bus.mem_rdata;
          2'd1: inst_d[23:16] = bus.mem_rdata;
          2'd2: inst_d[15:8]  = bus.mem_rdata;
          2'd3: inst_d[7:0]   = bus.mem_rdata;
        endcase
        rx_cnt_d = rx_cnt_q + 2'd1;
        if (rx_cnt_q == 2'd3) begin
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      track_q     <= '0;
      inst_q      <= '0;
      valid_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      track_q     <= track_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Bench for inst_fetch_sequencer: a MEM_LAT=1 and a MEM_LAT=3 instance share one stimulus stream.
// Each instance has its own byte-memory model.
module tb_inst_fetch_sequencer;
  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, flush, ack;
  logic [31:0] addr;
  logic [1:0]  st_a, st_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  inst_fetch_sequencer_if bus_a ();
  inst_fetch_sequencer_if bus_b ();

  inst_fetch_sequencer #(.MEM_BYTES(188), .MEM_LAT(1), .NOP_WORD(NOP)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .state_o(st_a));
  inst_fetch_sequencer #(.MEM_BYTES(188), .MEM_LAT(3), .NOP_WORD(NOP)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .state_o(st_b));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory models ----------------
  logic [7:0] mem [0:255];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [0:2];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:0]] : 8'hEE;
  endfunction

  always @(posedge clk) begin
    pipe_a    <= bus_a.mem_rd ? rd_byte(bus_a.mem_addr) : 8'h5A;
    pipe_b[0] <= bus_b.mem_rd ? rd_byte(bus_b.mem_addr) : 8'h5A;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.mem_rdata = pipe_a;
  assign bus_b.mem_rdata = pipe_b[2];
  assign bus_a.req = req;   assign bus_b.req = req;
  assign bus_a.addr = addr; assign bus_b.addr = addr;
  assign bus_a.flush = flush; assign bus_b.flush = flush;
  assign bus_a.ack = ack;   assign bus_b.ack = ack;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // req/addr must already be driven. This task waits for the accept edge (cycle 0) and then observes cycles 1..14.
  task automatic collect(input logic [31:0] a, output int cyc_a, output int cyc_b,
                         output logic [31:0] inst_a, output logic [31:0] inst_b,
                         output int rd_n, output int rd_first, output logic addr_ok);
    cyc_a = -1; cyc_b = -1; inst_a = '0; inst_b = '0;
    rd_n = 0; rd_first = -1; addr_ok = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus_a.mem_rd) begin
        if (rd_first < 0) rd_first = n;
        if (bus_a.mem_addr !== a + 32'(rd_n)) addr_ok = 1'b0;
        rd_n++;
      end
      if (bus_a.valid && cyc_a < 0) begin cyc_a = n; inst_a = bus_a.inst; end
      if (bus_b.valid && cyc_b < 0) begin cyc_b = n; inst_b = bus_b.inst; end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_inst;
    int          exp_cyc_a;
    int          exp_cyc_b;
    int          exp_rd;
  } vec_t;

  vec_t vecs [0:7];

  // ---------------- test sequence ----------------
  initial begin
    int          ca, cb, rn, rf, found;
    logic [31:0] ia, ib;
    logic        aok;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h00; mem[3] = 8'h14;

    vecs[0] = '{32'd0,          32'hE3A0_0014, 6, 8, 4};
    vecs[1] = '{32'd188,        NOP,           1, 1, 0};
    vecs[2] = '{32'd184,        32'h1D1C_1F1E, 6, 8, 4};
    vecs[3] = '{32'd185,        NOP,           1, 1, 0};
    vecs[4] = '{32'd100,        32'hC1C0_C3C2, 6, 8, 4};
    vecs[5] = '{32'hFFFF_FFFC,  NOP,           1, 1, 0};
    vecs[6] = '{32'd4,          32'hA1A0_A3A2, 6, 8, 4};
    vecs[7] = '{32'd187,        NOP,           1, 1, 0};

    rst = 1'b1; req = 1'b0; flush = 1'b0; ack = 1'b0; addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",    bus_a.valid,    32'd0);
    check("rst_inst",     bus_a.inst,     32'd0);
    check("rst_mem_rd",   bus_a.mem_rd,   32'd0);
    check("rst_mem_addr", bus_a.mem_addr, 32'd0);
    check("rst_state",    st_a,           32'd0);
    check("rst_ready",    bus_a.ready,    32'd1);
    @(posedge clk); #1; rst = 1'b0;

    // Table-driven fetches with ack held high.
    for (int v = 0; v < 8; v++) begin
      req = 1'b1; addr = vecs[v].addr; ack = 1'b1;
      collect(vecs[v].addr, ca, cb, ia, ib, rn, rf, aok);
      check($sformatf("v%0d_cyc_a", v),  ca, vecs[v].exp_cyc_a);
      check($sformatf("v%0d_inst_a", v), ia, vecs[v].exp_inst);
      check($sformatf("v%0d_cyc_b", v),  cb, vecs[v].exp_cyc_b);
      check($sformatf("v%0d_inst_b", v), ib, vecs[v].exp_inst);
      check($sformatf("v%0d_rd_cnt", v), rn, vecs[v].exp_rd);
      check($sformatf("v%0d_rd_first", v), rf, (vecs[v].exp_rd > 0) ? 1 : -1);
      check($sformatf("v%0d_rd_addr", v), aok, 32'd1);
    end

    // Backpressure: ack low for three cycles after valid.
    req = 1'b1; addr = 32'd4; ack = 1'b0; found = -1;
    @(posedge clk); #1; req = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus_a.valid) begin found = n; break; end
    end
    check("bp_valid_cycle", found, 6);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", bus_a.valid, 32'd1);
      check("bp_inst",  bus_a.inst,  32'hA1A0_A3A2);
      check("bp_ready", bus_a.ready, 32'd0);
      check("bp_state", st_a,        32'd3);
      @(posedge clk);
    end
    #1; ack = 1'b1;
    @(negedge clk);
    check("bp_valid_held",  bus_a.valid, 32'd1);
    check("bp_b_valid",     bus_b.valid, 32'd1);
    check("bp_b_inst",      bus_b.inst,  32'hA1A0_A3A2);
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready",  bus_a.ready, 32'd1);
    check("bp_idle_valid",  bus_a.valid, 32'd0);
    check("bp_b_released",  bus_b.valid, 32'd0);
    @(posedge clk); #1;

    // Flush during ISSUE, then refetch while late bytes are still returning.
    req = 1'b1; addr = 32'd0; ack = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    check("fl_ready_low", bus_a.ready,  32'd0);
    check("fl_rd_c3",     bus_a.mem_rd, 32'd1);
    @(posedge clk); #1; flush = 1'b0; req = 1'b1; addr = 32'd4;
    @(negedge clk);
    check("fl_rd_c4",    bus_a.mem_rd, 32'd0);
    check("fl_valid_c4", bus_a.valid,  32'd0);
    check("fl_ready_a",  bus_a.ready,  32'd1);
    check("fl_ready_b",  bus_b.ready,  32'd1);
    collect(32'd4, ca, cb, ia, ib, rn, rf, aok);
    check("fl_cyc_a",  ca, 6);
    check("fl_inst_a", ia, 32'hA1A0_A3A2);
    check("fl_cyc_b",  cb, 8);
    check("fl_inst_b", ib, 32'hA1A0_A3A2);
    check("fl_rd_cnt", rn, 4);

    // flush beats req in the same cycle.
    req = 1'b1; flush = 1'b1; addr = 32'd0;
    @(negedge clk);
    check("fp_ready", bus_a.ready, 32'd0);
    @(posedge clk); #1; flush = 1'b0; req = 1'b0;
    @(negedge clk);
    check("fp_state",  st_a,         32'd0);
    check("fp_mem_rd", bus_a.mem_rd, 32'd0);
    @(posedge clk); #1;

    // Flush drops a held NOP without ack.
    req = 1'b1; addr = 32'd188; ack = 1'b0;
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    check("fh_valid_c1", bus_a.valid, 32'd1);
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    check("fh_valid_c3", bus_a.valid, 32'd0);
    check("fh_state",    st_a,        32'd0);
    check("fh_b_valid",  bus_b.valid, 32'd0);
    @(posedge clk); #1; ack = 1'b1;

    // Reset in the middle of WAIT, then a clean fetch.
    req = 1'b1; addr = 32'd100; ack = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; req = 1'b1; addr = 32'd184;
    @(negedge clk);
    check("mr_valid_a",    bus_a.valid,    32'd0);
    check("mr_inst_a",     bus_a.inst,     32'd0);
    check("mr_mem_rd_a",   bus_a.mem_rd,   32'd0);
    check("mr_mem_addr_a", bus_a.mem_addr, 32'd0);
    check("mr_state_a",    st_a,           32'd0);
    check("mr_valid_b",    bus_b.valid,    32'd0);
    check("mr_inst_b",     bus_b.inst,     32'd0);
    check("mr_mem_rd_b",   bus_b.mem_rd,   32'd0);
    check("mr_mem_addr_b", bus_b.mem_addr, 32'd0);
    check("mr_state_b",    st_b,           32'd0);
    collect(32'd184, ca, cb, ia, ib, rn, rf, aok);
    check("mr_cyc_a",  ca, 6);
    check("mr_inst_a", ia, 32'h1D1C_1F1E);
    check("mr_cyc_b",  cb, 8);
    check("mr_inst_b", ib, 32'h1D1C_1F1E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
